// File: rtl/execute_cycle.sv
// ---------------------------------------------------------------------------
// execute_cycle
//
// Execute stage of the 5-stage RV32I pipeline.  Takes the ID/EX register
// outputs, applies operand forwarding, runs the ALU, resolves branch/jump
// direction and target, and registers the results into the EX/MEM register.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   RD1_E, RD2_E              register-file operands from ID/EX
//   ImmExtE, PCE, PCPlus4E    immediate, PC, PC+4 from ID/EX
//   InstrE                    instruction word (funct3 drives branch compare)
//   RdE                       destination register
//   RegWriteE, MemWriteE      write enables carried forward
//   JumpE, jalrE, BranchE     control-flow controls
//   ALUSrcE                   1: ALU operand B is the immediate
//   ALUControlE               ALU operation
//   ResultSrcE                writeback select carried forward
//   ForwardAE, ForwardBE      00 register, 01 ResultW, 10 ALUResultM
//   ResultW                   writeback-stage result (forwarding source)
//   PCSrcE, PCTargetE         combinational fetch redirect and address
//   *M                        EX/MEM register outputs
// ---------------------------------------------------------------------------
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] ImmExtE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [31:0] InstrE,
    input  logic [4:0]  RdE,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        JumpE,
    input  logic        jalrE,
    input  logic        BranchE,
    input  logic        ALUSrcE,
    input  logic [2:0]  ALUControlE,
    input  logic [1:0]  ResultSrcE,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ResultW,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M,
    output logic [31:0] InstrM,
    output logic [4:0]  RdM,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic [1:0]  ResultSrcM
);

    logic [31:0] src_a_e;
    logic [31:0] write_data_e;
    logic [31:0] src_b_e;
    logic [31:0] alu_result_e;
    logic [31:0] jalr_sum_e;
    logic        branch_cond_e;
    logic        eq_e;
    logic        lt_signed_e;
    logic        lt_unsigned_e;

    // Forwarding muxes.  ALUResultM is the registered output of this stage,
    // so selecting it never forms a combinational loop.  Code 11 is unused
    // and falls back to the register-file operand.
    always_comb begin
        src_a_e = RD1_E;
        case (ForwardAE)
            2'b01:   src_a_e = ResultW;
            2'b10:   src_a_e = ALUResultM;
            default: src_a_e = RD1_E;
        endcase
    end

    always_comb begin
        write_data_e = RD2_E;
        case (ForwardBE)
            2'b01:   write_data_e = ResultW;
            2'b10:   write_data_e = ALUResultM;
            default: write_data_e = RD2_E;
        endcase
    end

    assign src_b_e = ALUSrcE ? ImmExtE : write_data_e;

    always_comb begin
        alu_result_e = 32'd0;
        case (ALUControlE)
            3'b000: alu_result_e = src_a_e + src_b_e;
            3'b001: alu_result_e = src_a_e - src_b_e;
            3'b010: alu_result_e = src_a_e & src_b_e;
            3'b011: alu_result_e = src_a_e | src_b_e;
            3'b100: alu_result_e = src_a_e ^ src_b_e;
            3'b101: alu_result_e = {31'd0, ($signed(src_a_e) < $signed(src_b_e))};
            3'b110: alu_result_e = src_a_e << src_b_e[4:0];
            default: alu_result_e = src_a_e >> src_b_e[4:0];
        endcase
    end

    // Branch compare always uses forwarded rs2, never the immediate, so a
    // branch is resolved correctly even if ALUSrcE happens to be set.
    assign eq_e          = (src_a_e == write_data_e);
    assign lt_signed_e   = ($signed(src_a_e) < $signed(write_data_e));
    assign lt_unsigned_e = (src_a_e < write_data_e);

    always_comb begin
        branch_cond_e = 1'b0;
        case (InstrE[14:12])
            3'b000:  branch_cond_e = eq_e;
            3'b001:  branch_cond_e = ~eq_e;
            3'b100:  branch_cond_e = lt_signed_e;
            3'b101:  branch_cond_e = ~lt_signed_e;
            3'b110:  branch_cond_e = lt_unsigned_e;
            3'b111:  branch_cond_e = ~lt_unsigned_e;
            default: branch_cond_e = 1'b0;
        endcase
    end

    assign PCSrcE = JumpE | (BranchE & branch_cond_e);

    // jalr clears bit 0 of the computed address; the target is driven even
    // when no redirect is requested.
    assign jalr_sum_e = src_a_e + ImmExtE;
    assign PCTargetE  = jalrE ? {jalr_sum_e[31:1], 1'b0} : (PCE + ImmExtE);

    // EX/MEM register: captures every cycle, no enable, no flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALUResultM <= 32'd0;
            WriteDataM <= 32'd0;
            PCPlus4M   <= 32'd0;
            InstrM     <= 32'd0;
            RdM        <= 5'd0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
        end else begin
            ALUResultM <= alu_result_e;
            WriteDataM <= write_data_e;
            PCPlus4M   <= PCPlus4E;
            InstrM     <= InstrE;
            RdM        <= RdE;
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
        end
    end

endmodule

// File: doc/execute_cycle.md
# execute_cycle

Execute stage of the 5-stage RV32I pipeline. It consumes the ID/EX register outputs (operands, immediate, PC values, control bits, destination register, instruction word). It applies hazard-unit forwarding, computes the ALU result, and resolves branch/jump direction and target. Results are registered into the EX/MEM pipeline register that feeds the memory stage.

## Interface
Parameters:
- none; datapath fixed at 32 bits, register addresses 5 bits.

Ports:
- clk  in  1  clock; all registers update on rising edge
- rst  in  1  reset, asynchronous, active-high
- RD1_E, RD2_E  in  32  register-file operands from ID/EX
- ImmExtE, PCE, PCPlus4E, InstrE  in  32  immediate, PC, PC+4, instruction word from ID/EX
- RdE  in  5  destination register
- RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE  in  1  control from ID/EX
- ALUControlE  in  3  ALU operation
- ResultSrcE  in  2  writeback select: 00 ALU, 01 memory, 10 PC+4
- ForwardAE, ForwardBE  in  2  forwarding select: 00 register operand, 01 ResultW, 10 ALUResultM
- ResultW  in  32  writeback-stage result
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  32  redirect address (combinational)
- ALUResultM, WriteDataM, PCPlus4M, InstrM  out  32  EX/MEM register
- RdM  out  5  EX/MEM register
- RegWriteM, MemWriteM  out  1  EX/MEM register
- ResultSrcM  out  2  EX/MEM register

## Operation
- SrcAE = mux(ForwardAE): 00 RD1_E, 01 ResultW, 10 ALUResultM (the stage's own registered output). 11 is treated as 00.
- WriteDataE = same mux on RD2_E using ForwardBE.
- SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALUControlE encoding:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor
  - 101 slt: signed compare, result 0/1 zero-extended
  - 110 sll, 111 srl: shift amount SrcBE[4:0]
  - All arithmetic is modulo 2^32; overflow and carry are discarded.
- Branch compare uses SrcAE vs WriteDataE (forwarded rs2, never the immediate), selected by funct3 = InstrE[14:12]:
  - 000 beq, 001 bne, 100 blt (signed), 101 bge (signed), 110 bltu, 111 bgeu
  - 010/011 never taken
- TakenE = BranchE & compare result.
- PCSrcE = JumpE | TakenE.
- PCTargetE:
  - jalrE=1: (SrcAE + ImmExtE) & 0xFFFF_FFFE
  - otherwise: PCE + ImmExtE
  - Output regardless of PCSrcE.
- JumpE with jalrE=0 is jal; JumpE with jalrE=1 is jalr. jalrE without JumpE is treated as a no-redirect instruction.
- EX/MEM register captures ALUResultE, WriteDataE (forwarded), PCPlus4E, InstrE, RdE, RegWriteE, MemWriteE, ResultSrcE every cycle. There is no enable and no flush.
- Squashing wrong-path instructions is done upstream: the ID/EX register is zeroed, so a bubble arrives with all controls 0.
- The stage never squashes its own instruction when PCSrcE is asserted.

## Timing
- Forwarding mux, ALU, compare, PCSrcE and PCTargetE are purely combinational within the E cycle; they are valid the same cycle the ID/EX outputs are valid.
- Latency E to M: 1 cycle. Values present in cycle n appear on the *M outputs after edge n+1.
- Reset: every EX/MEM output is 0 immediately on rst assertion, independent of clk. Reset held mid-operation discards the in-flight instruction.
- Reset release: the first capture happens at the first rising edge after rst deasserts.
- During reset PCSrcE and PCTargetE follow the (reset, all-zero) ID/EX inputs: PCSrcE=0, PCTargetE=0.
- ForwardAE=10 uses ALUResultM as held before the current edge, i.e. the result of the immediately preceding instruction. There is no combinational loop.
- Simultaneous BranchE and JumpE: PCSrcE=1; target is chosen by jalrE as above.

## Test plan
- Reset: assert rst mid-cycle with nonzero *M -> all *M outputs 0 asynchronously; PCSrcE=0.
- ALU sweep, ForwardAE/BE=00, ALUSrcE=0, RD1_E=0xFFFF_FFF0, RD2_E=0x0000_0004:
  - add -> 0xFFFF_FFF4
  - sub -> 0xFFFF_FFEC
  - slt -> 1
  - sll -> 0xFFFF_FF00
  - srl -> 0x0FFF_FFFF
  - each appears on ALUResultM one cycle later
- Forwarding:
  - ForwardAE=10 with previous ALUResultM=0x10, add with RD2_E=5 -> ALUResultM=0x15
  - ForwardBE=01 with ResultW=0xAB, MemWriteE=1 -> WriteDataM=0xAB, MemWriteM=1
- Branches, PCE=0x100, ImmExtE=0xFFFF_FFF8:
  - blt with SrcA=0xFFFF_FFFF, rs2=1 -> PCSrcE=1, PCTargetE=0xF8
  - bltu with same operands -> PCSrcE=0
  - beq with equal operands -> PCSrcE=1
- Jumps:
  - jalr with SrcA=0x203, Imm=0x4 -> PCTargetE=0x206, PCSrcE=1; next cycle PCPlus4M=PCPlus4E, ResultSrcM=10
  - jal with PCE=0x40, Imm=0x20 -> PCTargetE=0x60
- Bubble: all-zero ID/EX inputs -> PCSrcE=0; next cycle RegWriteM=0, MemWriteM=0.
